// File: rtl/tmds_encoder_pipe.sv
// Pipelined N-channel TMDS encoder: control, video (DC-balanced 8b/10b), TERC4 data island and guard bands.
// Define TMDS_DISP_MON_EN to expose the per-channel running disparity on disp_mon.

module tmds_encoder_pipe #(
    parameter int NUM_CH  = 3,
    parameter int OUT_REG = 0
) (
    input  logic                 hdmi_clk,
    input  logic                 reset,
    input  logic [2:0]           mode,
    input  logic [8*NUM_CH-1:0]  data_in,
    input  logic [2*NUM_CH-1:0]  ctrl_in,
    input  logic [4*NUM_CH-1:0]  aux_in,
    output logic [10*NUM_CH-1:0] q_out
`ifdef TMDS_DISP_MON_EN
    ,
    output logic [5*NUM_CH-1:0]  disp_mon
`endif
);

    localparam logic [2:0] MODE_VIDEO     = 3'd1;
    localparam logic [2:0] MODE_VIDEO_GB  = 3'd2;
    localparam logic [2:0] MODE_ISLAND    = 3'd3;
    localparam logic [2:0] MODE_ISLAND_GB = 3'd4;

    localparam logic [9:0] RST_CODE = 10'b1101010100;
    localparam logic [9:0] GB_A     = 10'b1011001100;
    localparam logic [9:0] GB_B     = 10'b0100110011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising stage: XNOR chain for byte-heavy inputs, XOR otherwise
    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [3:0] n1;
        logic [8:0] qm;
        logic       use_xnor;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
        qm       = 9'd0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor) begin
                qm[i] = ~(qm[i-1] ^ d[i]);
            end else begin
                qm[i] = qm[i-1] ^ d[i];
            end
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] a);
        case (a)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            4'hF:    return 10'b1011000011;
            default: return 10'b1010011100;
        endcase
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            2'b11:   return 10'b1010101011;
            default: return 10'b1101010100;
        endcase
    endfunction

    logic [NUM_CH-1:0][8:0] qm_s;
    logic [NUM_CH-1:0][3:0] n1_s;
    logic [2:0]             mode_r;
    logic [NUM_CH-1:0][1:0] ctrl_r;
    logic [NUM_CH-1:0][3:0] aux_r;
    logic [NUM_CH-1:0][8:0] qm_r;
    logic [NUM_CH-1:0][3:0] n1_r;
    logic [NUM_CH-1:0][3:0] n0_r;
    logic [NUM_CH-1:0][9:0] sym_s;
    logic [NUM_CH-1:0][4:0] cnt_nxt_s;
    logic [NUM_CH-1:0][9:0] q2_r;
    logic [NUM_CH-1:0][4:0] cnt_r;

    // Per-channel q_m and its ones count for the video path
    always_comb begin
        qm_s = '0;
        n1_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            qm_s[i] = qm_encode(data_in[8*i +: 8]);
            n1_s[i] = ones8(qm_s[i][7:0]);
        end
    end

    // Stage 1: register mode, side-band inputs and the video q_m word
    always_ff @(posedge hdmi_clk or negedge reset) begin
        if (!reset) begin
            mode_r <= 3'd0;
            ctrl_r <= '0;
            aux_r  <= '0;
            qm_r   <= '0;
            n1_r   <= '0;
            n0_r   <= '0;
        end else begin
            mode_r <= mode;
            ctrl_r <= ctrl_in;
            aux_r  <= aux_in;
            qm_r   <= qm_s;
            n1_r   <= n1_s;
            for (int i = 0; i < NUM_CH; i++) begin
                n0_r[i] <= 4'd8 - n1_s[i];
            end
        end
    end

    // Stage 2 symbol select; disparity is two's complement and non-video periods zero it
    always_comb begin
        sym_s     = '0;
        cnt_nxt_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_r)
                MODE_VIDEO: begin
                    if ((cnt_r[i] == 5'd0) || (n1_r[i] == n0_r[i])) begin
                        sym_s[i] = {~qm_r[i][8], qm_r[i][8],
                                    qm_r[i][8] ? qm_r[i][7:0] : ~qm_r[i][7:0]};
                        if (qm_r[i][8]) begin
                            cnt_nxt_s[i] = cnt_r[i] + {1'b0, n1_r[i]} - {1'b0, n0_r[i]};
                        end else begin
                            cnt_nxt_s[i] = cnt_r[i] + {1'b0, n0_r[i]} - {1'b0, n1_r[i]};
                        end
                    end else if (((cnt_r[i][4] == 1'b0) && (n1_r[i] > n0_r[i])) ||
                                 ((cnt_r[i][4] == 1'b1) && (n0_r[i] > n1_r[i]))) begin
                        sym_s[i]     = {1'b1, qm_r[i][8], ~qm_r[i][7:0]};
                        cnt_nxt_s[i] = cnt_r[i] + {3'd0, qm_r[i][8], 1'b0}
                                       + {1'b0, n0_r[i]} - {1'b0, n1_r[i]};
                    end else begin
                        sym_s[i]     = {1'b0, qm_r[i][8], qm_r[i][7:0]};
                        cnt_nxt_s[i] = cnt_r[i] + {1'b0, n1_r[i]} - {1'b0, n0_r[i]}
                                       - {3'd0, ~qm_r[i][8], 1'b0};
                    end
                end
                MODE_VIDEO_GB: begin
                    if ((i % 3) == 32'sd1) begin
                        sym_s[i] = GB_B;
                    end else begin
                        sym_s[i] = GB_A;
                    end
                end
                MODE_ISLAND: begin
                    sym_s[i] = terc4(aux_r[i]);
                end
                MODE_ISLAND_GB: begin
                    if (i == 32'sd0) begin
                        sym_s[i] = terc4(aux_r[i]);
                    end else begin
                        sym_s[i] = GB_B;
                    end
                end
                default: begin
                    sym_s[i] = ctrl_code(ctrl_r[i]);
                end
            endcase
        end
    end

    // Stage 2: register symbols and running disparity
    always_ff @(posedge hdmi_clk or negedge reset) begin
        if (!reset) begin
            q2_r  <= {NUM_CH{RST_CODE}};
            cnt_r <= '0;
        end else begin
            q2_r  <= sym_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [NUM_CH-1:0][9:0] q3_r;
            // Optional retiming stage toward the serialisers
            always_ff @(posedge hdmi_clk or negedge reset) begin
                if (!reset) begin
                    q3_r <= {NUM_CH{RST_CODE}};
                end else begin
                    q3_r <= q2_r;
                end
            end
            assign q_out = q3_r;
`ifdef TMDS_DISP_MON_EN
            logic [NUM_CH-1:0][4:0] cnt3_r;
            // Keep the disparity monitor aligned with the delayed symbols
            always_ff @(posedge hdmi_clk or negedge reset) begin
                if (!reset) begin
                    cnt3_r <= '0;
                end else begin
                    cnt3_r <= cnt_r;
                end
            end
            assign disp_mon = cnt3_r;
`endif
        end else begin : g_no_out_reg
            assign q_out = q2_r;
`ifdef TMDS_DISP_MON_EN
            assign disp_mon = cnt_r;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Self-checking bench for tmds_encoder_pipe: directed vector table, randomized stimulus against a
// behavioural model, and a mid-stream reset; covers OUT_REG=0 (3 ch) and OUT_REG=1 (4 ch).

module tb_tmds_encoder_pipe;

    localparam logic [9:0] RC   = 10'b1101010100;
    localparam logic [9:0] GB_A = 10'b1011001100;
    localparam logic [9:0] GB_B = 10'b0100110011;
    localparam int         HN   = 1024;

    typedef struct {
        logic       rst;
        logic [2:0] mode;
        logic [7:0] d;
        logic [7:0] c;
        logic [3:0] a;
        logic [29:0] exp;
    } vec_t;

    logic        hdmi_clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic [31:0] data4;
    logic [7:0]  ctrl4;
    logic [15:0] aux4;
    logic [29:0] q0;
    logic [39:0] q1;
`ifdef TMDS_DISP_MON_EN
    logic [14:0] dm0;
    logic [19:0] dm1;
`endif

    always #5 hdmi_clk = ~hdmi_clk;

    tmds_encoder_pipe #(.NUM_CH(3), .OUT_REG(0)) dut0 (
        .hdmi_clk (hdmi_clk),
        .reset    (reset),
        .mode     (mode),
        .data_in  (data4[23:0]),
        .ctrl_in  (ctrl4[5:0]),
        .aux_in   (aux4[11:0]),
        .q_out    (q0)
`ifdef TMDS_DISP_MON_EN
        ,
        .disp_mon (dm0)
`endif
    );

    tmds_encoder_pipe #(.NUM_CH(4), .OUT_REG(1)) dut1 (
        .hdmi_clk (hdmi_clk),
        .reset    (reset),
        .mode     (mode),
        .data_in  (data4),
        .ctrl_in  (ctrl4),
        .aux_in   (aux4),
        .q_out    (q1)
`ifdef TMDS_DISP_MON_EN
        ,
        .disp_mon (dm1)
`endif
    );

    logic [39:0] hist_q [0:HN-1];
    logic [19:0] hist_c [0:HN-1];
    logic        tab_v  [0:HN-1];
    logic [29:0] tab_e  [0:HN-1];
    logic [9:0]  terc4_t [0:15];
    int          mcnt [4];
    int          cyc;
    int          n_checks;
    int          n_errors;
    vec_t        tab [17];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference symbol straight from the encoding rules, disparity kept as a plain integer
    function automatic logic [9:0] model_sym(input logic [2:0] m, input int ch, input logic [7:0] d,
                                             input logic [1:0] c, input logic [3:0] a,
                                             input int cnt_in, output int cnt_out);
        int         n1d, n1, n0;
        logic       xn;
        logic [8:0] qm;
        logic [9:0] s;
        cnt_out = 0;
        qm = 9'd0;
        case (m)
            3'd1: begin
                n1d = $countones(d);
                xn  = (n1d > 4) || (n1d == 4 && !d[0]);
                qm[0] = d[0];
                for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
                qm[8] = !xn;
                n1 = $countones(qm[7:0]);
                n0 = 8 - n1;
                if (cnt_in == 0 || n1 == n0) begin
                    s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                    cnt_out = cnt_in + (qm[8] ? (n1 - n0) : (n0 - n1));
                end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
                    s = {1'b1, qm[8], ~qm[7:0]};
                    cnt_out = cnt_in + 2 * int'(qm[8]) + n0 - n1;
                end else begin
                    s = {1'b0, qm[8], qm[7:0]};
                    cnt_out = cnt_in + n1 - n0 - (qm[8] ? 0 : 2);
                end
            end
            3'd2: s = (ch % 3 == 1) ? GB_B : GB_A;
            3'd3: s = terc4_t[a];
            3'd4: s = (ch == 0) ? terc4_t[a] : GB_B;
            default: begin
                case (c)
                    2'b00:   s = 10'b1101010100;
                    2'b01:   s = 10'b0010101011;
                    2'b10:   s = 10'b0101010100;
                    default: s = 10'b1010101011;
                endcase
            end
        endcase
        return s;
    endfunction

    // One pixel clock: sample outputs, drive the next inputs, record expectations
    task automatic step(input logic rst_v, input logic [2:0] m, input logic [31:0] d,
                        input logic [7:0] c, input logic [15:0] a,
                        input logic tv, input logic [29:0] te);
        logic        rst_prev;
        logic [39:0] e;
        logic [19:0] ec;
        logic [9:0]  s;
        int          nc;
        check("q_lat2", {10'd0, q0}, {10'd0, hist_q[cyc-2][29:0]});
        check("q_lat3", q1, hist_q[cyc-3]);
        if (tab_v[cyc-2]) check("tab_lat2", {10'd0, q0}, {10'd0, tab_e[cyc-2]});
        if (tab_v[cyc-3]) check("tab_lat3", {10'd0, q1[29:0]}, {10'd0, tab_e[cyc-3]});
`ifdef TMDS_DISP_MON_EN
        check("disp_lat2", {25'd0, dm0}, {25'd0, hist_c[cyc-2][14:0]});
        check("disp_lat3", {20'd0, dm1}, {20'd0, hist_c[cyc-3]});
`endif
        rst_prev = reset;
        reset = rst_v;
        mode  = m;
        data4 = d;
        ctrl4 = c;
        aux4  = a;
        tab_v[cyc] = tv;
        tab_e[cyc] = te;
        if (!rst_v) begin
            for (int ch = 0; ch < 4; ch++) mcnt[ch] = 0;
            hist_q[cyc] = {4{RC}};
            hist_c[cyc] = 20'd0;
            if (rst_prev) begin
                for (int k = 1; k <= 2; k++) begin
                    hist_q[cyc-k] = {4{RC}};
                    hist_c[cyc-k] = 20'd0;
                    tab_v[cyc-k]  = 1'b0;
                end
                #1;
                check("rst_async_q0", {10'd0, q0}, {10'd0, {3{RC}}});
                check("rst_async_q1", q1, {4{RC}});
`ifdef TMDS_DISP_MON_EN
                check("rst_async_disp", {5'd0, dm0, dm1}, 40'd0);
`endif
            end
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                s = model_sym(m, ch, d[8*ch +: 8], c[2*ch +: 2], a[4*ch +: 4], mcnt[ch], nc);
                mcnt[ch] = nc;
                e[10*ch +: 10] = s;
                ec[5*ch +: 5]  = nc[4:0];
            end
            hist_q[cyc] = e;
            hist_c[cyc] = ec;
        end
        cyc++;
        @(negedge hdmi_clk);
    endtask

    initial begin
        reset = 1'b0;
        mode  = 3'd0;
        data4 = 32'd0;
        ctrl4 = 8'd0;
        aux4  = 16'd0;
        n_checks = 0;
        n_errors = 0;
        cyc = 3;
        for (int i = 0; i < HN; i++) begin
            hist_q[i] = {4{RC}};
            hist_c[i] = 20'd0;
            tab_v[i]  = 1'b0;
            tab_e[i]  = 30'd0;
        end
        for (int ch = 0; ch < 4; ch++) mcnt[ch] = 0;
        terc4_t = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

        tab[0]  = '{1'b0, 3'd0, 8'h00, 8'h01, 4'h0, {RC, RC, RC}};
        tab[1]  = '{1'b0, 3'd0, 8'h00, 8'h01, 4'h0, {RC, RC, RC}};
        tab[2]  = '{1'b1, 3'd0, 8'h00, 8'h01, 4'h0, {RC, RC, 10'b0010101011}};
        tab[3]  = '{1'b1, 3'd1, 8'h00, 8'h00, 4'h0, {3{10'b0100000000}}};
        tab[4]  = '{1'b1, 3'd1, 8'h00, 8'h00, 4'h0, {3{10'b1111111111}}};
        tab[5]  = '{1'b1, 3'd1, 8'h00, 8'h00, 4'h0, {3{10'b0100000000}}};
        tab[6]  = '{1'b1, 3'd1, 8'h00, 8'h00, 4'h0, {3{10'b1111111111}}};
        tab[7]  = '{1'b1, 3'd0, 8'h00, 8'h00, 4'h0, {RC, RC, RC}};
        tab[8]  = '{1'b1, 3'd1, 8'h00, 8'h00, 4'h0, {3{10'b0100000000}}};
        tab[9]  = '{1'b1, 3'd3, 8'h00, 8'h00, 4'h0, {3{10'b1010011100}}};
        tab[10] = '{1'b1, 3'd3, 8'h00, 8'h00, 4'hF, {3{10'b1011000011}}};
        tab[11] = '{1'b1, 3'd4, 8'h00, 8'h00, 4'hF, {GB_B, GB_B, 10'b1011000011}};
        tab[12] = '{1'b1, 3'd2, 8'h00, 8'h00, 4'h0, {GB_A, GB_B, GB_A}};
        tab[13] = '{1'b1, 3'd6, 8'h00, 8'h1B, 4'h0, {10'b0010101011, 10'b0101010100, 10'b1010101011}};
        tab[14] = '{1'b1, 3'd5, 8'h00, 8'h00, 4'h0, {RC, RC, RC}};
        tab[15] = '{1'b1, 3'd1, 8'hFF, 8'h00, 4'h0, {3{10'b1000000000}}};
        tab[16] = '{1'b1, 3'd1, 8'h55, 8'h00, 4'h0, {3{10'b0100110011}}};

        @(negedge hdmi_clk);
        for (int k = 0; k < 17; k++) begin
            step(tab[k].rst, tab[k].mode, {4{tab[k].d}}, tab[k].c, {4{tab[k].a}}, 1'b1, tab[k].exp);
        end

        for (int k = 0; k < 400; k++) begin
            logic [2:0]  m;
            logic [31:0] d;
            int          r;
            r = $urandom_range(0, 9);
            m = (r < 5) ? 3'd1 : 3'($urandom_range(0, 7));
            d = $urandom;
            if (r == 0) d = 32'h0;
            if (r == 1) d = 32'hFFFF_FFFF;
            step(1'b1, m, d, 8'($urandom), 16'($urandom), 1'b0, 30'd0);
        end

        for (int k = 0; k < 5; k++) step(1'b1, 3'd1, 32'($urandom), 8'd0, 16'd0, 1'b0, 30'd0);
        step(1'b0, 3'd1, 32'h0, 8'd0, 16'd0, 1'b0, 30'd0);
        step(1'b0, 3'd1, 32'h0, 8'd0, 16'd0, 1'b0, 30'd0);
        for (int k = 0; k < 6; k++) step(1'b1, 3'd1, 32'h0, 8'd0, 16'd0, 1'b0, 30'd0);
        for (int k = 0; k < 4; k++) step(1'b1, 3'd0, 32'h0, 8'd0, 16'd0, 1'b0, 30'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
